edge_list_reader: RTL and testbench

//  Sequencer directly downstream of the data memory (dmem). Reads the graph

---
 rtl/edge_list_reader.sv | 193 +++++++++++++++++++
 tb/tb_edge_list_reader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_list_reader.sv
`default_nettype none
// ============================================================================
// Module      : edge_list_reader
// Description : Walks a graph image in dmem (header at BASE, packed edge
//               words after it) and streams one (u,v) edge per handshake.
//               Optional feature macro: EDGE_RANGE_CHECK_EN (drops edges whose
//               endpoints fall outside n_nodes and raises a sticky err).
// Revision    : 1.0 - initial release
// ============================================================================
module edge_list_reader #(
    parameter int                DATA_W = 32,
    parameter int                ADDR_W = 16,
    parameter logic [ADDR_W-1:0] BASE   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_a,
    input  logic [DATA_W-1:0] mem_rd,
    output logic [7:0]        n_nodes,
    output logic [7:0]        n_edges,
    output logic [15:0]       hdr_aux,
    output logic              e_valid,
    input  logic              e_ready,
    output logic [7:0]        e_u,
    output logic [7:0]        e_v,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR     = 3'd1,
        S_FETCH   = 3'd2,
        S_EMIT_HI = 3'd3,
        S_EMIT_LO = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state;
    logic [7:0]        r_remaining;
    logic [7:0]        w_remaining;
    logic [15:0]       r_word_lo;
    logic [15:0]       w_word_lo;
    logic [ADDR_W-1:0] w_mem_a;
    logic [7:0]        w_n_nodes;
    logic [7:0]        w_n_edges;
    logic [15:0]       w_hdr_aux;
    logic              w_e_valid;
    logic [7:0]        w_e_u;
    logic [7:0]        w_e_v;
    logic              w_fetch_ok;
    logic              w_lo_ok;
    logic              w_slot_done;

`ifdef EDGE_RANGE_CHECK_EN
    // An out-of-range edge is loaded with e_valid low, so its slot retires
    // on its own after one cycle without waiting for e_ready.
    assign w_fetch_ok  = (mem_rd[31:24] < n_nodes) && (mem_rd[23:16] < n_nodes);
    assign w_lo_ok     = (r_word_lo[15:8] < n_nodes) && (r_word_lo[7:0] < n_nodes);
    assign w_slot_done = e_valid ? e_ready : 1'b1;
`else
    assign w_fetch_ok  = 1'b1;
    assign w_lo_ok     = 1'b1;
    assign w_slot_done = e_ready;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            mem_a       <= '0;
            n_nodes     <= 8'd0;
            n_edges     <= 8'd0;
            hdr_aux     <= 16'd0;
            r_remaining <= 8'd0;
            r_word_lo   <= 16'd0;
            e_valid     <= 1'b0;
            e_u         <= 8'd0;
            e_v         <= 8'd0;
        end else begin
            r_state     <= w_state;
            mem_a       <= w_mem_a;
            n_nodes     <= w_n_nodes;
            n_edges     <= w_n_edges;
            hdr_aux     <= w_hdr_aux;
            r_remaining <= w_remaining;
            r_word_lo   <= w_word_lo;
            e_valid     <= w_e_valid;
            e_u         <= w_e_u;
            e_v         <= w_e_v;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_mem_a     = mem_a;
        w_n_nodes   = n_nodes;
        w_n_edges   = n_edges;
        w_hdr_aux   = hdr_aux;
        w_remaining = r_remaining;
        w_word_lo   = r_word_lo;
        w_e_valid   = e_valid;
        w_e_u       = e_u;
        w_e_v       = e_v;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state = S_HDR;
                    w_mem_a = BASE;
                end
            end
            S_HDR: begin
                w_n_nodes   = mem_rd[31:24];
                w_n_edges   = mem_rd[23:16];
                w_hdr_aux   = mem_rd[15:0];
                w_remaining = mem_rd[23:16];
                if (mem_rd[23:16] == 8'd0) begin
                    w_state = S_DONE;
                end else begin
                    w_state = S_FETCH;
                    w_mem_a = BASE + ADDR_W'(1);
                end
            end
            S_FETCH: begin
                // The high half goes straight to the output register so the
                // first edge of a word is presented the cycle after the read.
                w_word_lo = mem_rd[15:0];
                w_e_u     = mem_rd[31:24];
                w_e_v     = mem_rd[23:16];
                w_e_valid = w_fetch_ok;
                w_state   = S_EMIT_HI;
            end
            S_EMIT_HI: begin
                if (w_slot_done) begin
                    w_remaining = r_remaining - 8'd1;
                    if (r_remaining == 8'd1) begin
                        w_e_valid = 1'b0;
                        w_state   = S_DONE;
                    end else begin
                        w_e_u     = r_word_lo[15:8];
                        w_e_v     = r_word_lo[7:0];
                        w_e_valid = w_lo_ok;
                        w_state   = S_EMIT_LO;
                    end
                end
            end
            S_EMIT_LO: begin
                if (w_slot_done) begin
                    w_remaining = r_remaining - 8'd1;
                    w_e_valid   = 1'b0;
                    if (r_remaining == 8'd1) begin
                        w_state = S_DONE;
                    end else begin
                        w_mem_a = mem_a + ADDR_W'(1);
                        w_state = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state   = S_IDLE;
                w_e_valid = 1'b0;
            end
        endcase
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

`ifdef EDGE_RANGE_CHECK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_err <= 1'b0;
        end else if (((r_state == S_EMIT_HI) || (r_state == S_EMIT_LO)) && !e_valid) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_edge_list_reader.sv
`default_nettype none
// Bench for edge_list_reader: table of short images plus hand-written
// sequences for the long image, back-pressure, reset abort and range check.
module tb_edge_list_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] mem_a;
    logic [31:0] mem_rd;
    logic [7:0]  n_nodes;
    logic [7:0]  n_edges;
    logic [15:0] hdr_aux;
    logic        e_valid;
    logic        e_ready;
    logic [7:0]  e_u;
    logic [7:0]  e_v;
    logic        busy;
    logic        done;
    logic        err;

    edge_list_reader dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_a(mem_a), .mem_rd(mem_rd),
        .n_nodes(n_nodes), .n_edges(n_edges), .hdr_aux(hdr_aux),
        .e_valid(e_valid), .e_ready(e_ready), .e_u(e_u), .e_v(e_v),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    assign mem_rd = mem[mem_a[7:0]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_u [0:127];
    logic [7:0] exp_v [0:127];
    int         exp_n;
    logic [7:0] got_u [0:127];
    logic [7:0] got_v [0:127];
    int         got_n;

    typedef struct packed {
        logic [31:0]      hdr;
        logic [31:0]      w0;
        logic [31:0]      w1;
        int               n;
        logic [3:0][7:0]  eu;
        logic [3:0][7:0]  ev;
        int               off;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    // Drives one start, consumes the stream and compares against exp_*.
    task automatic run(input string name, input int mode, input int done_off, input int glitch_k);
        int         t0;
        int         ndone;
        int         done_at;
        bit         prev_stall;
        bit         prev_done;
        bit         finished;
        logic [7:0] pu;
        logic [7:0] pv;
        got_n = 0; ndone = 0; done_at = -1;
        prev_stall = 0; prev_done = 0; finished = 0; pu = 8'h0; pv = 8'h0;
        @(negedge clk);
        start   = 1'b1;
        e_ready = 1'b0;
        t0      = cyc + 1;
        for (int k = 0; k < 2000 && !finished; k++) begin
            @(negedge clk);
            start   = (k == glitch_k);
            e_ready = (mode == 0) ? 1'b1 : (((k / 2) % 2) == 1);
            if (prev_done) begin
                check({name, " busy after done"}, 32'(busy), 32'd0);
                finished = 1;
            end else begin
                if (prev_stall)
                    check({name, " stall stable"}, {15'd0, e_valid, e_u, e_v}, {15'd0, 1'b1, pu, pv});
                if (e_valid && e_ready) begin
                    if (got_n < 128) begin
                        got_u[got_n] = e_u;
                        got_v[got_n] = e_v;
                    end
                    got_n++;
                end
                prev_stall = e_valid && !e_ready;
                pu = e_u;
                pv = e_v;
                if (done) begin
                    ndone++;
                    done_at = cyc - t0 + 1;
                    prev_done = 1;
                    check({name, " busy in done"}, 32'(busy), 32'd1);
                end
            end
        end
        start   = 1'b0;
        e_ready = 1'b0;
        if (!finished) check({name, " timeout"}, 32'd0, 32'd1);
        check({name, " edge count"}, 32'(got_n), 32'(exp_n));
        for (int i = 0; i < exp_n && i < got_n && i < 128; i++)
            check($sformatf("%s edge%0d", name, i), {16'd0, got_u[i], got_v[i]}, {16'd0, exp_u[i], exp_v[i]});
        check({name, " done pulses"}, 32'(ndone), 32'd1);
        if (done_off >= 0) check({name, " done cycle"}, 32'(done_at), 32'(done_off));
    endtask

    task automatic load_long();
        clear_mem();
        exp_n = 74;
        for (int i = 0; i < 74; i++) begin
            exp_u[i] = 8'(i % 33);
            exp_v[i] = 8'((i * 7 + 3) % 33);
        end
        exp_u[0] = 8'h00; exp_v[0] = 8'h13;
        exp_u[1] = 8'h00; exp_v[1] = 8'h0a;
        exp_u[73] = 8'h1d; exp_v[73] = 8'h1f;
        mem[0] = 32'h214a0015;
        for (int i = 0; i < 74; i++) begin
            if (i % 2 == 0) mem[1 + i / 2][31:16] = {exp_u[i], exp_v[i]};
            else            mem[1 + i / 2][15:0]  = {exp_u[i], exp_v[i]};
        end
    endtask

    initial begin
        int  cnt;
        bit  leaked;

        vecs[0] = '{32'h10030000, 32'h01020304, 32'h05060000, 3, 32'h00050301, 32'h00060402, 7};
        vecs[1] = '{32'h10000000, 32'h00000000, 32'h00000000, 0, 32'h0,        32'h0,        2};
        vecs[2] = '{32'hff01beef, 32'haabbccdd, 32'h00000000, 1, 32'h000000aa, 32'h000000bb, 4};
        vecs[3] = '{32'h50020000, 32'h11223344, 32'h00000000, 2, 32'h00003311, 32'h00004422, 5};
        vecs[4] = '{32'h10040000, 32'h01020304, 32'h05060708, 4, 32'h07050301, 32'h08060402, 8};

        clear_mem();
        rst = 1'b1; start = 1'b1; e_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset beats start busy", 32'(busy), 32'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("reset mem_a", 32'(mem_a), 32'd0);
        check("reset e_valid/u/v", {15'd0, e_valid, e_u, e_v}, 32'd0);
        check("reset done/err", {30'd0, done, err}, 32'd0);
        check("reset header", {n_nodes, n_edges, hdr_aux}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            clear_mem();
            mem[0] = vecs[i].hdr;
            mem[1] = vecs[i].w0;
            mem[2] = vecs[i].w1;
            exp_n  = vecs[i].n;
            for (int j = 0; j < exp_n; j++) begin
                exp_u[j] = vecs[i].eu[j];
                exp_v[j] = vecs[i].ev[j];
            end
            run($sformatf("vec%0d", i), 0, vecs[i].off, -1);
            check($sformatf("vec%0d header", i), {n_nodes, n_edges, hdr_aux}, vecs[i].hdr);
        end

        load_long();
        run("long", 0, 113, -1);
        check("long n_nodes", 32'(n_nodes), 32'h21);
        check("long n_edges", 32'(n_edges), 32'h4a);
        check("long hdr_aux", 32'(hdr_aux), 32'h0015);
`ifndef EDGE_RANGE_CHECK_EN
        check("err tied low", 32'(err), 32'd0);
`endif
        repeat (3) @(negedge clk);
        check("header held", {n_nodes, n_edges, hdr_aux}, 32'h214a0015);

        run("backpressure", 1, -1, -1);

        @(negedge clk);
        start = 1'b1; e_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (e_valid) begin
                cnt++;
                if (cnt == 10) begin
                    rst = 1'b1;
                    break;
                end
            end
        end
        check("abort reached edge 10", 32'(cnt), 32'd10);
        @(negedge clk);
        rst = 1'b0;
        check("abort e_valid", 32'(e_valid), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        leaked = 0;
        repeat (5) begin
            @(negedge clk);
            if (e_valid || busy) leaked = 1;
        end
        check("abort stays idle", 32'(leaked), 32'd0);
        e_ready = 1'b0;
        run("replay with ignored start", 0, 113, 20);

`ifdef EDGE_RANGE_CHECK_EN
        clear_mem();
        mem[0] = 32'h04030000;
        mem[1] = 32'h01020109;
        mem[2] = 32'h03000000;
        exp_n = 2;
        exp_u[0] = 8'h01; exp_v[0] = 8'h02;
        exp_u[1] = 8'h03; exp_v[1] = 8'h00;
        run("range", 0, 7, -1);
        check("range err set", 32'(err), 32'd1);
        clear_mem();
        mem[0] = vecs[3].hdr;
        mem[1] = vecs[3].w0;
        exp_n = 2;
        exp_u[0] = 8'h11; exp_v[0] = 8'h22;
        exp_u[1] = 8'h33; exp_v[1] = 8'h44;
        run("range clear", 0, 5, -1);
        check("range err cleared by start", 32'(err), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
